// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB request arbiter.
package apb_arb_pkg;

    localparam int unsigned APB_ADDR_W = 33;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic found;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        grant = '0;
        // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant[i] = found && (idx == IDX_W'(i));
        end
        any = found;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NUM_REQ requesters.
// Optional ISSUE watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]      req_wdata,
    input  logic [NUM_REQ*APB_STRB_W-1:0]  req_strb,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic                           m_transfer,
    output logic                           m_read,
    output logic [ADDR_W-1:0]              m_addr,
    output logic [DATA_W-1:0]              m_wdata,
    output logic [APB_STRB_W-1:0]          m_strb,
    input  logic                           m_penable,
    input  logic                           m_pready,
    input  logic                           m_pslverr,
    input  logic [DATA_W-1:0]              m_prdata,
    output logic                           busy,
    output logic [IDX_W-1:0]               grant_id
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e           state, state_next;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 load;
    logic                 finish;
    logic                 done;
    logic                 abort;
    logic                 expired;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign done  = m_penable & m_pready;
    assign abort = m_pslverr & ~done;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Counts ISSUE cycles; expires on the TIMEOUT_CYCLES-th one.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_cnt <= '0;
        end else if (load) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign expired = (state == ISSUE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                req_ready = PRESET ? '0 : pick_grant;
                if (pick_any) begin
                    load       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (done || abort || expired) begin
                    finish     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, response capture and round-robin pointer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr        <= '0;
            grant_id   <= '0;
            m_read     <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_strb     <= '0;
            m_transfer <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            m_transfer <= (state_next == ISSUE);
            busy       <= (state_next != IDLE);
            rsp_valid  <= (state_next == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
            if (load) begin
                grant_id <= pick_idx;
                m_read   <= req_read[pick_idx];
                m_addr   <= req_addr[32'(pick_idx) * ADDR_W +: ADDR_W];
                m_wdata  <= req_wdata[32'(pick_idx) * DATA_W +: DATA_W];
                m_strb   <= req_strb[32'(pick_idx) * APB_STRB_W +: APB_STRB_W];
            end
            if (finish) begin
                rsp_rdata <= (done && m_read) ? m_prdata : '0;
                rsp_err   <= done ? m_pslverr : 1'b1;
            end
            if (state == RESP) begin
                ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
            end
        end
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares the single APB master between `NUM_REQ` requesters (e.g. CPU port, DMA port). It accepts one command at a time over a valid/ready handshake and drives the master's command inputs (`transfer`, read/write, address, write data, strobes). It watches APB completion, then returns read data and error status to the granted requester as a one-cycle response pulse.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `ADDR_W`, default 33: address width; bit 32 selects slave 1.
- `DATA_W`, default 32: data width.
- `TIMEOUT_CYCLES`, default 16: watchdog limit. Used only with `APB_ARB_TIMEOUT_EN`.
- `PCLK`  in  1  clock; all state on rising edge.
- `PRESET`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  command pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot accept; a command is taken when `valid & ready` at a PCLK edge.
- `req_read`  in  NUM_REQ  1 = read, 0 = write.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `req_strb`  in  NUM_REQ*4  packed byte strobes.
- `rsp_valid`  out  NUM_REQ  one-cycle, one-hot completion pulse.
- `rsp_rdata`  out  DATA_W  read data; valid with `rsp_valid`.
- `rsp_err`  out  1  error flag; valid with `rsp_valid`.
- `m_transfer`  out  1  drives the master's `transfer`.
- `m_read`  out  1  drives the master's `READ_WRITE` (1 = read).
- `m_addr`  out  ADDR_W  drives both `get_r_paddr` and `get_w_paddr`.
- `m_wdata`  out  DATA_W  drives the master's `get_w_data_in`.
- `m_strb`  out  4  drives the master's `PSTRB`.
- `m_penable`, `m_pready`, `m_pslverr`  in  1 each  APB bus status.
- `m_prdata`  in  DATA_W  APB read data.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any `req_valid` is high, pick the winner by round-robin. Search starts at `ptr`; the first valid index at or after `ptr` (mod NUM_REQ) wins.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - On the clock edge, latch the winner's read flag, address, wdata and strb, and latch `grant_id`. Go to ISSUE.
- ISSUE:
  - `m_transfer` = 1. The `m_*` command outputs come from the latched registers and stay stable for the whole state.
  - Completion = `m_penable & m_pready`. On completion, capture `m_prdata` (reads only; writes capture 0) and capture `m_pslverr` into `rsp_err`. Go to RESP.
  - If `m_pslverr` = 1 without completion: abort, `rsp_err` = 1, `rsp_rdata` = 0, go to RESP.
- RESP:
  - `m_transfer` = 0.
  - `rsp_valid[grant_id]` = 1 for exactly one cycle.
  - `ptr` ← `grant_id` + 1, wrapping to 0 at NUM_REQ.
  - Go to IDLE.
- Requesters whose `req_valid` is high outside IDLE see `req_ready` = 0 and must hold their command stable until accepted.
- Simultaneous requests are resolved only through `ptr`. A requester that stays valid is served within NUM_REQ grants.

## Timing
- Reset values: all outputs 0, state IDLE, `ptr` = 0 (requester 0 highest priority).
- Reset asserted mid-transfer: `m_transfer` drops asynchronously, no response is issued, and the in-flight command is discarded.
- Minimum latency from accept edge to `rsp_valid`, with zero wait states: 3 cycles (master SETUP, master ACCESS, RESP). Each PREADY-low access cycle adds 1 cycle.
- Back-to-back throughput: one command per 4 cycles minimum. The IDLE cycle is mandatory so the master sees `transfer` low and returns to its own IDLE.
- `rsp_rdata` and `rsp_err` hold their values until the next RESP.

## Configuration
- Macro: `APB_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears when ISSUE is entered and increments every ISSUE cycle.
  - When it reaches `TIMEOUT_CYCLES` without completion: go to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - Completion and timeout in the same cycle: completion wins.
- Undefined: no counter; ISSUE waits indefinitely.

## Structure
- Package `apb_arb_pkg` holds:
  - the state enum (IDLE = 2'b00, ISSUE = 2'b01, RESP = 2'b10);
  - `APB_ADDR_W` = 33, `APB_DATA_W` = 32, `APB_STRB_W` = 4.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, `ptr`.
  - Outputs: one-hot grant, index, any-valid.

## Test plan
- Single read: req0 reads 0x0_0000_0010 and the slave returns 0xDEADBEEF with zero wait states → `m_transfer` high for 2 cycles, `rsp_valid` = 2'b01, `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0.
- Contention: both requesters hold `req_valid` continuously after reset → grant order 0, 1, 0, 1; each `rsp_valid` is one-hot and one cycle long.
- Write: req1 writes 0x11223344 to 0x1_0000_0004 with strb 4'b0101 → `m_addr[32]` = 1, `m_read` = 0, `m_strb` = 4'b0101 for all of ISSUE; `rsp_rdata` = 0.
- Wait states: PREADY low for 3 access cycles → accept-to-`rsp_valid` = 6 cycles, and `m_*` stay stable throughout.
- Slave error: `m_pslverr` = 1 at completion → `rsp_err` = 1, then back to IDLE, and the next command completes with `rsp_err` = 0.
- Timeout and reset:
  - With `APB_ARB_TIMEOUT_EN` and PREADY stuck low → `rsp_err` = 1 exactly 16 cycles after ISSUE entry.
  - `PRESET` pulsed mid-ISSUE → all outputs 0 immediately, and `ptr` = 0 afterwards.
